seq_loop_monitor: RTL and testbench

Parametrised, synthesizable monitor for one sequential loop in an HLS-generated FSM. It generalises the per-loop cosim probe to N pre-loop, iteration-end and quit states. It also adds behaviour the probe lacks: iteration counting, trip-count capture, execution counting and sticky protocol-error detection. It attaches to a design FSM's state register in the cosim bench and in on-chip debug builds.

---
 rtl/seq_loop_monitor.sv | 92 +++++++++
 tb/tb_seq_loop_monitor.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/seq_loop_monitor.sv
// seq_loop_monitor: tracks entries, iterations, exits and protocol errors of one sequential loop in an HLS FSM.
// Ports: clock/reset (async active-low); cur_state is the watched FSM state; the *_states/*_valid
// inputs define the pre-loop, iteration-end and quit state sets; iter_start_state/loop_quit_state/
// one_state_loop describe the loop; finish is the end-of-run strobe. Outputs: in_loop, saturating
// iter/trip/exec counters, trip_valid pulse, sticky err_entry/err_finish, done pulse.
module seq_loop_monitor #(
  parameter int FSM_WIDTH = 2,
  parameter int N_PRE = 2,
  parameter int N_END = 1,
  parameter int N_QUIT = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [FSM_WIDTH-1:0]        cur_state,
  input  logic [N_PRE-1:0]            pre_states_valid,
  input  logic [N_PRE*FSM_WIDTH-1:0]  pre_loop_states,
  input  logic [N_END-1:0]            iter_end_states_valid,
  input  logic [N_END*FSM_WIDTH-1:0]  iter_end_states,
  input  logic [N_QUIT-1:0]           quit_states_valid,
  input  logic [N_QUIT*FSM_WIDTH-1:0] quit_loop_states,
  input  logic [FSM_WIDTH-1:0]        iter_start_state,
  input  logic [FSM_WIDTH-1:0]        loop_quit_state,
  input  logic                        one_state_loop,
  input  logic                        finish,
  output logic                        in_loop,
  output logic [CNT_WIDTH-1:0]        iter_cnt,
  output logic [CNT_WIDTH-1:0]        trip_cnt,
  output logic                        trip_valid,
  output logic [CNT_WIDTH-1:0]        exec_cnt,
  output logic                        err_entry,
  output logic                        err_finish,
  output logic                        done
);
  typedef enum logic {IDLE, LOOP} state_t;
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;
  state_t state, state_nx;
  logic [FSM_WIDTH-1:0] prev_state;
  logic prev_valid, is_pre, is_end, is_quit, at_start, self_loop, entry, back, leave, illegal;
  always_comb begin
    is_pre = 1'b0;
    is_end = 1'b0;
    is_quit = 1'b0;
    for (int k = 0; k < N_PRE; k++)
      if (pre_states_valid[k] && pre_loop_states[k*FSM_WIDTH +: FSM_WIDTH] == prev_state) is_pre = 1'b1;
    for (int k = 0; k < N_END; k++)
      if (iter_end_states_valid[k] && iter_end_states[k*FSM_WIDTH +: FSM_WIDTH] == prev_state) is_end = 1'b1;
    for (int k = 0; k < N_QUIT; k++)
      if (quit_states_valid[k] && quit_loop_states[k*FSM_WIDTH +: FSM_WIDTH] == prev_state) is_quit = 1'b1;
  end
  // self_loop: staying in the single-state body is a legal re-arrival at iter_start_state
  assign at_start  = cur_state == iter_start_state;
  assign self_loop = one_state_loop && prev_state == iter_start_state;
  assign entry     = prev_valid && state == IDLE && at_start && is_pre;
  assign back      = prev_valid && state == LOOP && at_start && (is_end || self_loop) && !leave;
  assign leave     = prev_valid && state == LOOP && cur_state == loop_quit_state && is_quit;
  assign illegal   = prev_valid && at_start && !entry && !back && !leave && !self_loop;
  assign in_loop   = state == LOOP;
  always_comb begin
    state_nx = state;
    if (leave) state_nx = IDLE;
    else if (entry) state_nx = LOOP;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_state <= '0;
      prev_valid <= 1'b0;
      iter_cnt <= '0;
      trip_cnt <= '0;
      trip_valid <= 1'b0;
      exec_cnt <= '0;
      err_entry <= 1'b0;
      err_finish <= 1'b0;
      done <= 1'b0;
    end else begin
      prev_state <= cur_state;
      prev_valid <= 1'b1;
      trip_valid <= leave;
      done <= finish;
      if (entry) iter_cnt <= CNT_WIDTH'(1);
      else if (back && iter_cnt != CMAX) iter_cnt <= iter_cnt + 1'b1;
      if (leave) trip_cnt <= iter_cnt;
      if (leave && exec_cnt != CMAX) exec_cnt <= exec_cnt + 1'b1;
      if (illegal) err_entry <= 1'b1;
      if (finish && state == LOOP) err_finish <= 1'b1;
    end
  end
endmodule

// File: tb/tb_seq_loop_monitor.sv
// tb_seq_loop_monitor: directed tests for seq_loop_monitor at CNT_WIDTH 16 and 3.
module tb_seq_loop_monitor;
  logic clock = 1'b0, reset = 1'b0, one_state_loop = 1'b0, finish = 1'b0;
  logic [1:0] cur_state = '0, iter_start_state = 2'd1, loop_quit_state = 2'd3;
  logic [1:0] pre_states_valid = 2'b01;
  logic [3:0] pre_loop_states = 4'b1100;
  logic [0:0] iter_end_states_valid = 1'b1, quit_states_valid = 1'b1;
  logic [1:0] iter_end_states = 2'd2, quit_loop_states = 2'd2;
  logic in_loop, trip_valid, err_entry, err_finish, done;
  logic [15:0] iter_cnt, trip_cnt, exec_cnt;
  logic s_in_loop, s_trip_valid, s_err_entry, s_err_finish, s_done;
  logic [2:0] s_iter_cnt, s_trip_cnt, s_exec_cnt;
  int checks = 0, passed = 0;

  always #5 clock = ~clock;

  seq_loop_monitor dut (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .pre_states_valid(pre_states_valid), .pre_loop_states(pre_loop_states),
    .iter_end_states_valid(iter_end_states_valid), .iter_end_states(iter_end_states),
    .quit_states_valid(quit_states_valid), .quit_loop_states(quit_loop_states),
    .iter_start_state(iter_start_state), .loop_quit_state(loop_quit_state),
    .one_state_loop(one_state_loop), .finish(finish),
    .in_loop(in_loop), .iter_cnt(iter_cnt), .trip_cnt(trip_cnt), .trip_valid(trip_valid),
    .exec_cnt(exec_cnt), .err_entry(err_entry), .err_finish(err_finish), .done(done)
  );

  seq_loop_monitor #(.CNT_WIDTH(3)) dut_small (
    .clock(clock), .reset(reset), .cur_state(cur_state),
    .pre_states_valid(pre_states_valid), .pre_loop_states(pre_loop_states),
    .iter_end_states_valid(iter_end_states_valid), .iter_end_states(iter_end_states),
    .quit_states_valid(quit_states_valid), .quit_loop_states(quit_loop_states),
    .iter_start_state(iter_start_state), .loop_quit_state(loop_quit_state),
    .one_state_loop(one_state_loop), .finish(finish),
    .in_loop(s_in_loop), .iter_cnt(s_iter_cnt), .trip_cnt(s_trip_cnt), .trip_valid(s_trip_valid),
    .exec_cnt(s_exec_cnt), .err_entry(s_err_entry), .err_finish(s_err_finish), .done(s_done)
  );

  task automatic step(input logic [1:0] s);
    cur_state = s;
    @(posedge clock);
    #1;
  endtask

  task automatic cfg(input logic [1:0] end_s, input logic [1:0] quit_s, input logic [1:0] lq, input logic one);
    pre_states_valid = 2'b01;
    pre_loop_states = 4'b1100;
    iter_start_state = 2'd1;
    iter_end_states = end_s;
    quit_loop_states = quit_s;
    loop_quit_state = lq;
    one_state_loop = one;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    finish = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    cfg(2'd2, 2'd2, 2'd3, 1'b0);
    reset = 1'b0;
    #2;
    checks++; if ({in_loop, trip_valid, err_entry, err_finish, done} !== 5'b0) $display("FAIL reset_flags: got %b want 00000", {in_loop, trip_valid, err_entry, err_finish, done}); else passed++;
    checks++; if ({iter_cnt, trip_cnt, exec_cnt} !== 48'b0) $display("FAIL reset_counters: got %0d/%0d/%0d want 0/0/0", iter_cnt, trip_cnt, exec_cnt); else passed++;
    do_reset();
  endtask

  task automatic test_basic();
    cfg(2'd2, 2'd2, 2'd3, 1'b0);
    do_reset();
    step(0);
    checks++; if (in_loop !== 1'b0) $display("FAIL basic_idle: got %0b want 0", in_loop); else passed++;
    step(1);
    checks++; if (in_loop !== 1'b1 || iter_cnt !== 16'd1) $display("FAIL basic_entry: got in_loop=%0b iter=%0d want 1/1", in_loop, iter_cnt); else passed++;
    step(2); step(1); step(2); step(1);
    checks++; if (iter_cnt !== 16'd3) $display("FAIL basic_iter: got %0d want 3", iter_cnt); else passed++;
    step(2);
    checks++; if (trip_valid !== 1'b0) $display("FAIL basic_trip_early: got %0b want 0", trip_valid); else passed++;
    step(3);
    checks++; if (in_loop !== 1'b0 || trip_cnt !== 16'd3 || trip_valid !== 1'b1 || exec_cnt !== 16'd1) $display("FAIL basic_exit: got in_loop=%0b trip=%0d tv=%0b exec=%0d want 0/3/1/1", in_loop, trip_cnt, trip_valid, exec_cnt); else passed++;
    step(0);
    checks++; if (trip_valid !== 1'b0 || trip_cnt !== 16'd3 || err_entry !== 1'b0) $display("FAIL basic_after: got tv=%0b trip=%0d err=%0b want 0/3/0", trip_valid, trip_cnt, err_entry); else passed++;
  endtask

  task automatic test_one_state();
    cfg(2'd1, 2'd1, 2'd2, 1'b1);
    do_reset();
    step(0);
    repeat (5) step(1);
    checks++; if (in_loop !== 1'b1 || iter_cnt !== 16'd5) $display("FAIL one_state_iter: got in_loop=%0b iter=%0d want 1/5", in_loop, iter_cnt); else passed++;
    step(2);
    checks++; if (in_loop !== 1'b0 || trip_cnt !== 16'd5 || trip_valid !== 1'b1 || err_entry !== 1'b0) $display("FAIL one_state_exit: got in_loop=%0b trip=%0d tv=%0b err=%0b want 0/5/1/0", in_loop, trip_cnt, trip_valid, err_entry); else passed++;
  endtask

  task automatic test_illegal();
    cfg(2'd2, 2'd2, 2'd3, 1'b0);
    do_reset();
    step(3); step(1);
    checks++; if (err_entry !== 1'b1 || in_loop !== 1'b0) $display("FAIL illegal_entry: got err=%0b in_loop=%0b want 1/0", err_entry, in_loop); else passed++;
    step(2); step(0);
    checks++; if (err_entry !== 1'b1) $display("FAIL illegal_sticky: got %0b want 1", err_entry); else passed++;
    step(1);
    checks++; if (in_loop !== 1'b1 || err_entry !== 1'b1) $display("FAIL illegal_reentry: got in_loop=%0b err=%0b want 1/1", in_loop, err_entry); else passed++;
  endtask

  task automatic test_finish();
    cfg(2'd2, 2'd2, 2'd3, 1'b0);
    do_reset();
    finish = 1'b1; step(0); finish = 1'b0;
    checks++; if (done !== 1'b1 || err_finish !== 1'b0) $display("FAIL finish_idle: got done=%0b errf=%0b want 1/0", done, err_finish); else passed++;
    step(1); step(2); step(1);
    finish = 1'b1; step(2); finish = 1'b0;
    checks++; if (done !== 1'b1 || err_finish !== 1'b1 || iter_cnt !== 16'd2 || in_loop !== 1'b1) $display("FAIL finish_loop: got done=%0b errf=%0b iter=%0d in_loop=%0b want 1/1/2/1", done, err_finish, iter_cnt, in_loop); else passed++;
    step(1);
    checks++; if (done !== 1'b0 || iter_cnt !== 16'd3 || err_finish !== 1'b1) $display("FAIL finish_after: got done=%0b iter=%0d errf=%0b want 0/3/1", done, iter_cnt, err_finish); else passed++;
  endtask

  task automatic test_saturation();
    cfg(2'd2, 2'd2, 2'd3, 1'b0);
    do_reset();
    step(0);
    repeat (10) begin step(1); step(2); end
    checks++; if (iter_cnt !== 16'd10 || s_iter_cnt !== 3'd7) $display("FAIL sat_iter: got %0d/%0d want 10/7", iter_cnt, s_iter_cnt); else passed++;
    step(3);
    checks++; if (trip_cnt !== 16'd10 || s_trip_cnt !== 3'd7 || s_exec_cnt !== 3'd1) $display("FAIL sat_trip: got %0d/%0d exec=%0d want 10/7/1", trip_cnt, s_trip_cnt, s_exec_cnt); else passed++;
  endtask

  task automatic test_exit_priority();
    cfg(2'd2, 2'd2, 2'd1, 1'b0);
    do_reset();
    step(0); step(1); step(2); step(1);
    checks++; if (in_loop !== 1'b0 || trip_valid !== 1'b1 || trip_cnt !== 16'd1 || iter_cnt !== 16'd1 || err_entry !== 1'b0) $display("FAIL exit_priority: got in_loop=%0b tv=%0b trip=%0d iter=%0d err=%0b want 0/1/1/1/0", in_loop, trip_valid, trip_cnt, iter_cnt, err_entry); else passed++;
  endtask

  task automatic test_reset_mid_loop();
    cfg(2'd2, 2'd2, 2'd3, 1'b0);
    do_reset();
    step(0); step(1); step(2); step(3); step(0); step(1); step(2); step(1);
    checks++; if (in_loop !== 1'b1 || iter_cnt !== 16'd2 || exec_cnt !== 16'd1) $display("FAIL mid_pre: got in_loop=%0b iter=%0d exec=%0d want 1/2/1", in_loop, iter_cnt, exec_cnt); else passed++;
    reset = 1'b0;
    #1;
    checks++; if ({in_loop, trip_valid, err_entry, err_finish, done} !== 5'b0 || {iter_cnt, trip_cnt, exec_cnt} !== 48'b0) $display("FAIL mid_async: got flags=%b iter=%0d trip=%0d exec=%0d want 0", {in_loop, trip_valid, err_entry, err_finish, done}, iter_cnt, trip_cnt, exec_cnt); else passed++;
    @(posedge clock);
    #1;
    reset = 1'b1;
    step(1);
    checks++; if (in_loop !== 1'b0 || err_entry !== 1'b0) $display("FAIL mid_first_ignored: got in_loop=%0b err=%0b want 0/0", in_loop, err_entry); else passed++;
    step(0); step(1);
    checks++; if (in_loop !== 1'b1 || iter_cnt !== 16'd1) $display("FAIL mid_reentry: got in_loop=%0b iter=%0d want 1/1", in_loop, iter_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_one_state();
    test_illegal();
    test_finish();
    test_saturation();
    test_exit_priority();
    test_reset_mid_loop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
